axis_rr_frame_arbiter: RTL

Frame-aware round-robin arbiter that shares one AXI4-Stream sink between `S_COUNT` AXI4-Stream sources. Its usual sink is a downstream `axis_fifo` input. A grant is issued at frame start and held until the granted source's `tlast` beat is accepted, so frames from different sources never interleave. Output is registered, and each beat is tagged with the source index on `m_axis_tid`.

---
 rtl/axis_rr_frame_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axis_rr_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_rr_frame_arbiter
// Description : Frame-aware round-robin arbiter sharing one AXI4-Stream sink
//               between S_COUNT sources. Grants are held from the first beat
//               of a frame until its tlast beat is accepted, so frames never
//               interleave. The output stage is registered and every beat is
//               tagged with its source index on m_axis_tid.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rr_frame_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic                          status_busy,
  output logic [ID_WIDTH-1:0]           status_grant
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]   status_grant_q, status_grant_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  logic [DATA_WIDTH-1:0] s_data [S_COUNT];
  logic [USER_WIDTH-1:0] s_user [S_COUNT];

  logic                  out_ready;
  logic                  accept;
  logic [ID_WIDTH-1:0]   rr_idx;
  logic [ID_WIDTH-1:0]   sel;
  logic                  sel_found;

  // Split the packed source buses into per-source lanes.
  generate
    for (genvar i = 0; i < S_COUNT; i++) begin : g_unpack
      assign s_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign s_user[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
    end
  endgenerate

  // The output register can take a new beat when empty or being drained.
  assign out_ready = m_axis_tready || !m_tvalid_q;

  // Round-robin pick: first valid source after last_grant, wrapping mod S_COUNT.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    rr_idx    = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      rr_idx = ID_WIDTH'((int'(last_grant_q) + k) % S_COUNT);
      if (!sel_found && s_axis_tvalid[rr_idx]) begin
        sel       = rr_idx;
        sel_found = 1'b1;
      end
    end
  end

  // Next-state logic for arbitration FSM, source readies and output stage.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    status_grant_d = status_grant_q;
    m_tdata_d      = m_tdata_q;
    m_tvalid_d     = m_tvalid_q;
    m_tlast_d      = m_tlast_q;
    m_tid_d        = m_tid_q;
    m_tuser_d      = m_tuser_q;
    s_axis_tready  = '0;
    accept         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d        = sel;
          last_grant_d   = sel;
          status_grant_d = sel;
          state_d        = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s_axis_tready[grant_q] = out_ready;
        accept = s_axis_tvalid[grant_q] && out_ready;
        if (accept && s_axis_tlast[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (out_ready) begin
      m_tvalid_d = accept;
      if (accept) begin
        m_tdata_d = s_data[grant_q];
        m_tlast_d = s_axis_tlast[grant_q];
        m_tid_d   = grant_q;
        m_tuser_d = s_user[grant_q];
      end
    end
  end

  // State and output registers; last_grant starts at S_COUNT-1 so source 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      last_grant_q   <= ID_WIDTH'(S_COUNT - 1);
      status_grant_q <= '0;
      m_tdata_q      <= '0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      m_tid_q        <= '0;
      m_tuser_q      <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      status_grant_q <= status_grant_d;
      m_tdata_q      <= m_tdata_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tlast_q      <= m_tlast_d;
      m_tid_q        <= m_tid_d;
      m_tuser_q      <= m_tuser_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tuser  = m_tuser_q;
  assign status_busy   = (state_q == ST_BUSY);
  assign status_grant  = status_grant_q;

endmodule
`default_nettype wire
